e203_tcm_icb2sram: RTL and testbench
====================================

Name: e203_tcm_icb2sram

Overview:
- Initiator-side controller for one TCM SRAM port (ITCM or DTCM).
- Accepts ICB commands from the core/bus fabric and drives the SRAM macro's cs/we/addr/wem/din pins.
- Captures dout one cycle later and returns ordered ICB responses.
- Provides flow-through 1-cycle read latency, a 2-entry response buffer for rsp_ready backpressure, address-range error checking, and a RAM clock-enable for the external clock gater.

Parameters:
- ICB_AW, 32, ICB byte-address width.
- DW, 32, data width; DW/8 byte lanes.
- MW, 4, write-mask width (DW/8).
- RAM_AW, 14, SRAM word-address width (region = 2^RAM_AW words).
- BASE_ADDR, 32'h8000_0000, region base; the low RAM_AW+log2(MW) bits must be zero.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- icb_cmd_valid  input  1  command valid.
- icb_cmd_ready  output  1  command accept.
- icb_cmd_addr  input  ICB_AW  byte address.
- icb_cmd_read  input  1  1 = read, 0 = write.
- icb_cmd_wdata  input  DW  write data.
- icb_cmd_wmask  input  MW  byte-write mask.
- icb_rsp_valid  output  1  response valid.
- icb_rsp_ready  input  1  response accept.
- icb_rsp_rdata  output  DW  read data.
- icb_rsp_err  output  1  address error.
- ram_cs  output  1  SRAM chip select.
- ram_we  output  1  SRAM write enable.
- ram_addr  output  RAM_AW  SRAM word address.
- ram_wem  output  MW  SRAM byte-write mask.
- ram_din  output  DW  SRAM write data.
- ram_dout  input  DW  SRAM read data, valid the cycle after a cs read.
- ram_clk_en  output  1  enable for the RAM clock gater.

Behaviour:
- State: pend (1 bit), pend_err, pend_rd; 2-entry response FIFO (cnt 0..2, rptr, wptr), entry = {rdata, err}.
- Reset: pend=0, cnt=0, pointers=0. Consequently icb_cmd_ready=1, icb_rsp_valid=0, ram_cs=0 and ram_clk_en=0 unless icb_cmd_valid=1. Reset asserted mid-operation drops in-flight responses with no further RAM access.
- Command acceptance:
  - icb_cmd_ready = (pend + cnt) < 2; purely from registers, no combinational path from icb_rsp_ready.
  - cmd_hsk = icb_cmd_valid & icb_cmd_ready.
- In-range check: in_rng = icb_cmd_addr[ICB_AW-1:RAM_AW+log2(MW)] equals the same bits of BASE_ADDR.
- RAM drive (combinational, same cycle as cmd_hsk):
  - ram_cs = cmd_hsk & in_rng.
  - ram_we = ~icb_cmd_read.
  - ram_addr = icb_cmd_addr[RAM_AW+1:2].
  - ram_wem = icb_cmd_wmask when writing, else 0.
  - ram_din = icb_cmd_wdata.
  - Out-of-range commands: ram_cs=0 and no RAM access.
- Pending stage: on cmd_hsk, pend<=1, pend_err<=~in_rng, pend_rd<=icb_cmd_read. Otherwise pend<=0 unless a new command is accepted.
- Pending payload:
  - rdata = ram_dout if pend_rd & ~pend_err, else 0.
  - err = pend_err.
- Response output:
  - If cnt>0: the FIFO head drives rsp. If pend=1, pending data is pushed into the FIFO (ordering preserved).
  - If cnt=0 and pend=1: flow-through; rsp_valid=1 with the pending payload. If icb_rsp_ready=0, the payload is pushed to the FIFO.
  - rsp_hsk pops the head when cnt>0.
  - Simultaneous push and pop leaves cnt unchanged. Pointers wrap modulo 2.
- Latency and throughput: read/write response is valid the cycle after command acceptance when unstalled. With icb_rsp_ready held at 1, back-to-back throughput is 1 command/cycle.
- Overflow is impossible (credit limit 2). The FIFO must never push when cnt=2; assertion required.
- Write response: rdata=0, err=0. Byte mask all-zero is still a legal access with cs=1.
- ram_clk_en = icb_cmd_valid | pend.

Decomposition:
- Shared package e203_tcm_pkg:
  - E203_TCM_RSP_DEPTH=2.
  - Default base constants for ITCM and DTCM.
  - Response entry struct {rdata, err}.
- Sub-module e203_tcm_rsp_fifo: 2-entry synchronous FIFO with push/pop/cnt and head data, asynchronous active-low reset.

Test Plan:
- Read 0x8000_0010 with ram_dout=0xDEAD_BEEF, rsp_ready=1:
  - Cycle 0: ram_cs=1, we=0, addr=0x0004.
  - Cycle 1: rsp_valid=1, rdata=0xDEAD_BEEF, err=0.
- Write 0x8000_0008, wdata=0x1234_5678, wmask=4'b0011:
  - Cycle 0: cs=1, we=1, addr=0x0002, wem=4'b0011, din=0x1234_5678.
  - Cycle 1: rsp err=0, rdata=0.
- Read 0x9000_0000 (out of range): ram_cs stays 0; the next cycle gives rsp err=1, rdata=0.
- Four back-to-back reads with rsp_ready=1 and RAM model data=addr: cmd_ready stays 1; four responses on consecutive cycles, in order.
- Backpressure with rsp_ready=0:
  - Two reads are accepted; cmd_ready drops to 0 from cycle 2; rsp_valid holds the first data stable.
  - Raising rsp_ready drains both in order, then cmd_ready=1.
- rst_n asserted with cnt=2: outputs immediately return to reset values (rsp_valid=0, cmd_ready=1); no stale response after release.

Source files
------------

// File: rtl/e203_tcm_pkg.sv
// Shared constants and types for the TCM ICB-to-SRAM controllers.
package e203_tcm_pkg;

  // Response buffer depth; also the command credit limit.
  localparam int E203_TCM_RSP_DEPTH = 2;
  localparam int E203_TCM_CNT_W     = $clog2(E203_TCM_RSP_DEPTH + 1);

  // Default region bases for the two tightly-coupled memories.
  localparam logic [31:0] E203_ITCM_BASE = 32'h8000_0000;
  localparam logic [31:0] E203_DTCM_BASE = 32'h9000_0000;

  localparam int E203_TCM_DW = 32;

  // One buffered ICB response.
  typedef struct packed {
    logic [E203_TCM_DW-1:0] rdata;
    logic                   err;
  } tcm_rsp_t;

endpackage

// File: rtl/e203_tcm_icb2sram_if.sv
// ICB command/response bundle between the fabric and a TCM controller.
interface e203_tcm_icb2sram_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_read;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/e203_tcm_rsp_fifo.sv
// Small synchronous response FIFO with occupancy count and head output.
module e203_tcm_rsp_fifo
  import e203_tcm_pkg::*;
#(
  parameter int  DEPTH   = E203_TCM_RSP_DEPTH,
  parameter type entry_t = tcm_rsp_t
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  entry_t                    push_data,
  input  logic                      pop,
  output entry_t                    head,
  output logic [E203_TCM_CNT_W-1:0] cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rptr, wptr;

  // Pointers and occupancy; a simultaneous push and pop leaves cnt unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Entry storage needs no reset; cnt qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign head = mem[rptr];

  // The credit limit upstream must keep us from ever overflowing.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (cnt != E203_TCM_CNT_W'(DEPTH)));

endmodule

// File: rtl/e203_tcm_icb2sram.sv
// ICB initiator to single-port TCM SRAM: 1-cycle read latency with
// flow-through response path and a 2-entry buffer behind rsp_ready.
module e203_tcm_icb2sram
  import e203_tcm_pkg::*;
#(
  parameter int          ICB_AW    = 32,
  parameter int          DW        = 32,
  parameter int          MW        = 4,
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = E203_ITCM_BASE
) (
  input  logic                clk,
  input  logic                rst_n,
  e203_tcm_icb2sram_if.slave  icb,
  output logic                ram_cs,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [MW-1:0]       ram_wem,
  output logic [DW-1:0]       ram_din,
  input  logic [DW-1:0]       ram_dout,
  output logic                ram_clk_en
);

  // Byte-offset bits below the word address, then the region tag above it.
  localparam int BW  = $clog2(MW);
  localparam int OFS = RAM_AW + BW;
  localparam int CW  = E203_TCM_CNT_W;
  localparam logic [ICB_AW-1:0] BASE = ICB_AW'(BASE_ADDR);

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic          pend, pend_err, pend_rd;
  logic [CW-1:0] cnt;
  logic          cmd_hsk, in_rng;
  logic          fifo_empty, push, pop;
  rsp_t          pend_pl, head;

  // Credit check from registers only: pending beat plus buffered beats.
  assign icb.cmd_ready = ((CW+1)'(pend) + (CW+1)'(cnt)) < (CW+1)'(E203_TCM_RSP_DEPTH);
  assign cmd_hsk       = icb.cmd_valid & icb.cmd_ready;
  assign in_rng        = (icb.cmd_addr[ICB_AW-1:OFS] == BASE[ICB_AW-1:OFS]);

  // SRAM pins are driven straight from the accepted command.
  assign ram_cs     = cmd_hsk & in_rng;
  assign ram_we     = ~icb.cmd_read;
  assign ram_addr   = icb.cmd_addr[OFS-1:BW];
  assign ram_wem    = icb.cmd_read ? '0 : icb.cmd_wmask;
  assign ram_din    = icb.cmd_wdata;
  assign ram_clk_en = icb.cmd_valid | pend;

  // Pending stage: one beat waiting for the SRAM's registered dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_err <= 1'b0;
      pend_rd  <= 1'b0;
    end else begin
      pend <= cmd_hsk;
      if (cmd_hsk) begin
        pend_err <= ~in_rng;
        pend_rd  <= icb.cmd_read;
      end
    end
  end

  // Only in-range reads return SRAM data; writes and errors return zero.
  assign pend_pl.rdata = (pend_rd & ~pend_err) ? ram_dout : '0;
  assign pend_pl.err   = pend_err;

  // Older buffered beats go first; the pending beat bypasses only when empty.
  assign fifo_empty    = (cnt == '0);
  assign push          = pend & (~fifo_empty | ~icb.rsp_ready);
  assign pop           = ~fifo_empty & icb.rsp_ready;
  assign icb.rsp_valid = ~fifo_empty | pend;
  assign icb.rsp_rdata = fifo_empty ? pend_pl.rdata : head.rdata;
  assign icb.rsp_err   = fifo_empty ? pend_pl.err   : head.err;

  e203_tcm_rsp_fifo #(
    .DEPTH   (E203_TCM_RSP_DEPTH),
    .entry_t (rsp_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pend_pl),
    .pop       (pop),
    .head      (head),
    .cnt       (cnt)
  );

endmodule

// File: tb/tb_e203_tcm_icb2sram.sv
// Directed bench: single-beat vector table plus multi-cycle sequences.
module tb_e203_tcm_icb2sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_cs, ram_we, ram_clk_en;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din, ram_dout;

  int checks = 0;
  int errors = 0;

  bit          use_ovr = 1'b0;
  logic [31:0] dout_ovr = '0;

  always #5 clk = ~clk;

  e203_tcm_icb2sram_if #(.AW(32), .DW(32), .MW(4)) icb ();

  e203_tcm_icb2sram dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .icb        (icb),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wem    (ram_wem),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_clk_en (ram_clk_en)
  );

  // SRAM model: read data = word address unless overridden; garbage otherwise.
  always @(posedge clk) begin
    if (ram_cs)
      ram_dout <= ram_we ? 32'h5A5A_5A5A : (use_ovr ? dout_ovr : {18'h0, ram_addr});
    else
      ram_dout <= 32'hA5A5_A5A5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Step to just after the next rising edge (drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic rd,
                       input logic [31:0] wd, input logic [3:0] wm);
    icb.cmd_valid = v;
    icb.cmd_addr  = a;
    icb.cmd_read  = rd;
    icb.cmd_wdata = wd;
    icb.cmd_wmask = wm;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] dout;
    logic        cs;
    logic [13:0] raddr;
    logic [3:0]  wem;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h8000_0010, 1'b1, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b1, 14'h0004, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h8000_0008, 1'b0, 32'h1234_5678, 4'h3, 32'h0,         1'b1, 14'h0002, 4'h3, 32'h0,         1'b0};
    vecs[2] = '{32'h9000_0000, 1'b1, 32'h0,         4'h0, 32'h1111_1111, 1'b0, 14'h0000, 4'h0, 32'h0,         1'b1};
    vecs[3] = '{32'h8000_FFFC, 1'b0, 32'hCAFE_F00D, 4'h0, 32'h0,         1'b1, 14'h3FFF, 4'h0, 32'h0,         1'b0};
    vecs[4] = '{32'h7FFF_FFFC, 1'b0, 32'h1111_2222, 4'hF, 32'h0,         1'b0, 14'h3FFF, 4'hF, 32'h0,         1'b1};
    vecs[5] = '{32'h8000_FFFC, 1'b1, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b1, 14'h3FFF, 4'h0, 32'h0BAD_F00D, 1'b0};
    vecs[6] = '{32'h8001_0000, 1'b1, 32'h0,         4'h0, 32'h2222_3333, 1'b0, 14'h0000, 4'h0, 32'h0,         1'b1};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    icb.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #5;
    chk("rst_cmd_ready", {31'h0, icb.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, icb.rsp_valid}, 32'd0);
    chk("rst_ram_cs",    {31'h0, ram_cs},        32'd0);
    chk("rst_clk_en",    {31'h0, ram_clk_en},    32'd0);
    tick();
    rst_n = 1'b1;

    // Single transactions with rsp_ready=1.
    use_ovr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      dout_ovr = vecs[i].dout;
      drive(1'b1, vecs[i].addr, vecs[i].rd, vecs[i].wdata, vecs[i].wmask);
      #4;
      chk($sformatf("v%0d_cmd_ready", i), {31'h0, icb.cmd_ready}, 32'd1);
      chk($sformatf("v%0d_cs", i),   {31'h0, ram_cs},   {31'h0, vecs[i].cs});
      chk($sformatf("v%0d_we", i),   {31'h0, ram_we},   {31'h0, ~vecs[i].rd});
      chk($sformatf("v%0d_addr", i), {18'h0, ram_addr}, {18'h0, vecs[i].raddr});
      chk($sformatf("v%0d_wem", i),  {28'h0, ram_wem},  {28'h0, vecs[i].wem});
      if (!vecs[i].rd) chk($sformatf("v%0d_din", i), ram_din, vecs[i].wdata);
      chk($sformatf("v%0d_clk_en", i), {31'h0, ram_clk_en}, 32'd1);
      tick();
      drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      #4;
      chk($sformatf("v%0d_cs_idle", i), {31'h0, ram_cs}, 32'd0);
      chk($sformatf("v%0d_rsp_valid", i), {31'h0, icb.rsp_valid}, 32'd1);
      chk($sformatf("v%0d_rdata", i), icb.rsp_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_err", i),   {31'h0, icb.rsp_err}, {31'h0, vecs[i].err});
      chk($sformatf("v%0d_clk_en_pend", i), {31'h0, ram_clk_en}, 32'd1);
      tick();
      #4;
      chk($sformatf("v%0d_rsp_done", i), {31'h0, icb.rsp_valid}, 32'd0);
      chk($sformatf("v%0d_clk_en_off", i), {31'h0, ram_clk_en}, 32'd0);
    end
    use_ovr = 1'b0;

    // Four back-to-back reads; dout = word address.
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) drive(1'b1, 32'h8000_0000 + 32'(4 * k), 1'b1, 32'h0, 4'h0);
      else       drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      #4;
      if (k < 4) chk($sformatf("b2b%0d_cmd_ready", k), {31'h0, icb.cmd_ready}, 32'd1);
      if (k > 0) begin
        chk($sformatf("b2b%0d_rsp_valid", k), {31'h0, icb.rsp_valid}, 32'd1);
        chk($sformatf("b2b%0d_rdata", k), icb.rsp_rdata, 32'(k - 1));
      end
    end
    tick();
    #4;
    chk("b2b_idle", {31'h0, icb.rsp_valid}, 32'd0);

    // Backpressure: two reads held behind rsp_ready=0, then drained in order.
    icb.rsp_ready = 1'b0;
    tick();
    drive(1'b1, 32'h8000_0020, 1'b1, 32'h0, 4'h0);
    #4;
    chk("bp0_cmd_ready", {31'h0, icb.cmd_ready}, 32'd1);
    tick();
    drive(1'b1, 32'h8000_0024, 1'b1, 32'h0, 4'h0);
    #4;
    chk("bp1_cmd_ready", {31'h0, icb.cmd_ready}, 32'd1);
    chk("bp1_rsp_valid", {31'h0, icb.rsp_valid}, 32'd1);
    chk("bp1_rdata", icb.rsp_rdata, 32'h8);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    #4;
    chk("bp2_cmd_ready", {31'h0, icb.cmd_ready}, 32'd0);
    chk("bp2_rdata", icb.rsp_rdata, 32'h8);
    tick();
    #4;
    chk("bp3_cmd_ready", {31'h0, icb.cmd_ready}, 32'd0);
    chk("bp3_rsp_valid", {31'h0, icb.rsp_valid}, 32'd1);
    chk("bp3_rdata", icb.rsp_rdata, 32'h8);
    tick();
    icb.rsp_ready = 1'b1;
    #4;
    chk("bp4_cmd_ready", {31'h0, icb.cmd_ready}, 32'd0);
    chk("bp4_rdata", icb.rsp_rdata, 32'h8);
    tick();
    #4;
    chk("bp5_rsp_valid", {31'h0, icb.rsp_valid}, 32'd1);
    chk("bp5_rdata", icb.rsp_rdata, 32'h9);
    chk("bp5_cmd_ready", {31'h0, icb.cmd_ready}, 32'd1);
    tick();
    #4;
    chk("bp6_rsp_valid", {31'h0, icb.rsp_valid}, 32'd0);
    chk("bp6_cmd_ready", {31'h0, icb.cmd_ready}, 32'd1);

    // Reset with the buffer full: everything drops, nothing replays.
    icb.rsp_ready = 1'b0;
    tick();
    drive(1'b1, 32'h8000_0030, 1'b1, 32'h0, 4'h0);
    tick();
    drive(1'b1, 32'h8000_0034, 1'b1, 32'h0, 4'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    tick();
    #1;
    chk("rf_full_cmd_ready", {31'h0, icb.cmd_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rf_rsp_valid", {31'h0, icb.rsp_valid}, 32'd0);
    chk("rf_cmd_ready", {31'h0, icb.cmd_ready}, 32'd1);
    chk("rf_ram_cs",    {31'h0, ram_cs},        32'd0);
    tick();
    rst_n = 1'b1;
    icb.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #4;
      chk($sformatf("rf_post%0d_rsp_valid", k), {31'h0, icb.rsp_valid}, 32'd0);
      chk($sformatf("rf_post%0d_ram_cs", k),    {31'h0, ram_cs},        32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
